// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector (1..MAX_LEN bits).
// Runtime pattern/length load, runtime overlap select, registered match pulse.
// Optional feature macro SEQDET_COUNT_EN adds a saturating match_count output.
module seq_detector_prog #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
  parameter int                 DEFAULT_LEN     = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sequence_in,
  input  logic                           in_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           overlap_en,
  output logic                           detector_out
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]               match_count
`endif
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
  localparam logic [LW-1:0] RST_LEN = LW'((DEFAULT_LEN > MAX_LEN) ? MAX_LEN : DEFAULT_LEN);

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               det_d;
  logic [LW:0]        fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] cand;
  logic               hit;
  state_t             state;

  // State is a view of the length/fill registers rather than separate flops.
  always_comb begin
    fill_inc = {1'b0, fill_q} + (LW+1)'(1);
    state    = HUNT;
    if (len_q == '0)
      state = IDLE;
    else if (fill_inc < {1'b0, len_q})
      state = FILL;
  end

  // Compare only the low len_q bits of the history plus the incoming bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LW'(i) < len_q);
    cand = {hist_q[MAX_LEN-2:0], sequence_in};
    hit  = (state == HUNT) && ((cand & mask) == (pat_q & mask));
  end

  // Next-state: config load wins over a bit offered on the same edge.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > MAX_L) ? MAX_L : cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = cand;
      det_d  = hit;
      if (hit && !overlap_en)
        fill_d = '0;  // non-overlap: next match needs len_q fresh bits
      else if (fill_inc >= {1'b0, len_q})
        fill_d = len_q;
      else
        fill_d = fill_inc[LW-1:0];
    end
  end

  // Configuration, history and match-pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q        <= DEFAULT_PATTERN;
      len_q        <= RST_LEN;
      hist_q       <= '0;
      fill_q       <= '0;
      detector_out <= 1'b0;
    end else begin
      pat_q        <= pat_d;
      len_q        <= len_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      detector_out <= det_d;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter, cleared by reset or a config load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (cfg_load)
      cnt_q <= '0;
    else if (in_valid && hit && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_count = cnt_q;
`else
  // Without the counter CNT_W sizes nothing; keep it referenced.
  if (CNT_W > 0) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed test-plan steps followed by a random
// phase, all checked against a queue-based model of the matching rules.
module tb_seq_detector_prog;
  localparam int ML = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       sequence_in, in_valid, cfg_load, overlap_en;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       det, det2;
`ifdef SEQDET_COUNT_EN
  logic [7:0] cnt;
  logic [1:0] cnt2;
`endif

  int errors = 0;
  int checks = 0;

  // model: bits accepted since the last clear, newest at the back
  bit         fresh[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_det;
  int         m_cnt, m_cnt2;

  always #5 clock = ~clock;

  seq_detector_prog dut (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .overlap_en(overlap_en), .detector_out(det)
`ifdef SEQDET_COUNT_EN
    , .match_count(cnt)
`endif
  );

  seq_detector_prog #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .overlap_en(overlap_en), .detector_out(det2)
`ifdef SEQDET_COUNT_EN
    , .match_count(cnt2)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ":det"}, 32'(det), 32'(m_det));
    chk({tag, ":det2"}, 32'(det2), 32'(m_det));
`ifdef SEQDET_COUNT_EN
    chk({tag, ":cnt"}, 32'(cnt), m_cnt);
    chk({tag, ":cnt2"}, 32'(cnt2), m_cnt2);
`endif
  endtask

  task automatic model_reset();
    fresh.delete();
    m_pat  = 8'b0000_1011;
    m_len  = 4;
    m_det  = 0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  // Applies one rising edge worth of behaviour using the driven inputs.
  task automatic model_edge();
    bit hit;
    if (cfg_load) begin
      m_pat  = cfg_pattern;
      m_len  = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
      fresh.delete();
      m_det  = 0;
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (in_valid) begin
      fresh.push_back(sequence_in);
      if (fresh.size() > ML) void'(fresh.pop_front());
      hit = 0;
      if (m_len > 0 && fresh.size() >= m_len) begin
        hit = 1;
        // pattern bit [len-1] is the oldest of the last len bits
        for (int i = 0; i < m_len; i++)
          if (fresh[fresh.size() - m_len + i] != m_pat[m_len-1-i]) hit = 0;
      end
      m_det = hit;
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!overlap_en) fresh.delete();
      end
    end else begin
      m_det = 0;
    end
  endtask

  task automatic cyc(bit v, bit b, string tag);
    in_valid    = v;
    sequence_in = b;
    cfg_load    = 1'b0;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic send(logic [15:0] bits, int n, string tag);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], tag);
  endtask

  // Load with a random bit offered alongside; the load must win.
  task automatic load(logic [7:0] pat, logic [3:0] len);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    in_valid    = 1'b1;
    sequence_in = 1'($urandom);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all("load");
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(posedge clock);
    @(negedge clock);
    check_all("reset_hold");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sequence_in = 0; in_valid = 0; cfg_load = 0;
    overlap_en = 0; cfg_pattern = '0; cfg_len = '0;
    model_reset();
    @(negedge clock);
    do_reset();
    chk("reset_det", 32'(det), 32'd0);

    // default pattern 1011, non-overlap
    send(16'b1011, 4, "t1");
    chk("t1_pulse", 32'(det), 32'd1);
`ifdef SEQDET_COUNT_EN
    chk("t1_count", 32'(cnt), 32'd1);
`endif
    cyc(1'b0, 1'b0, "t1_after");
    chk("t1_drop", 32'(det), 32'd0);

    // overlap vs non-overlap on 1011011
    do_reset();
    overlap_en = 1'b1;
    send(16'b1011011, 7, "t2o");
    chk("t2o_pulse7", 32'(det), 32'd1);
`ifdef SEQDET_COUNT_EN
    chk("t2o_count", 32'(cnt), 32'd2);
`endif
    do_reset();
    overlap_en = 1'b0;
    send(16'b1011011, 7, "t2n");
    chk("t2n_nopulse7", 32'(det), 32'd0);

    // gaps between every bit
    do_reset();
    cyc(1, 1, "t3"); cyc(0, 0, "t3gap");
    cyc(1, 0, "t3"); cyc(0, 1, "t3gap");
    cyc(1, 1, "t3"); cyc(0, 0, "t3gap");
    cyc(1, 1, "t3");
    chk("t3_pulse", 32'(det), 32'd1);
    cyc(0, 1, "t3gap");

    // 8-bit pattern E5, then len 0, then len clamp
    load(8'hE5, 4'd8);
    send(16'b1110_0101, 8, "t4");
    chk("t4_pulse", 32'(det), 32'd1);
`ifdef SEQDET_COUNT_EN
    chk("t4_count", 32'(cnt), 32'd1);
`endif
    load(8'hE5, 4'd0);
    send(16'b1110_0101_1110_0101, 16, "t4z");
    load(8'hE5, 4'd12);
    send(16'b1110_0101, 8, "t4c");
    chk("t4_clamp_pulse", 32'(det), 32'd1);

    // reset mid-sequence
    do_reset();
    send(16'b101, 3, "t5pre");
    do_reset();
    cyc(1, 1, "t5one");
    chk("t5_nopulse", 32'(det), 32'd0);
    do_reset();
    send(16'b1011, 4, "t5full");
    chk("t5_pulse", 32'(det), 32'd1);

    // single-bit pattern, back-to-back pulses, 2-bit counter saturation
    overlap_en = 1'b1;
    load(8'h01, 4'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, "t6");
      chk("t6_pulse", 32'(det), 32'd1);
`ifdef SEQDET_COUNT_EN
      chk("t6_cnt2", 32'(cnt2), (i < 3) ? i + 1 : 3);
`endif
    end

    // random phase
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) overlap_en = ~overlap_en;
      if ($urandom_range(0, 39) == 0)
        load(8'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 12))
                                                       : 4'($urandom_range(1, 3)));
      else if ($urandom_range(0, 149) == 0)
        do_reset();
      else
        cyc($urandom_range(0, 3) != 0, 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
